// File: rtl/lsq_pkg.sv
// Shared definitions for the LSQ partition reconfiguration controller.
//   - NUM_PARTS / NUM_PARTS_LOG : partition count taken from `STRUCT_PARTS_LSQ
//   - lsq_state_e               : controller state encoding (IDLE, DRAIN, WAKE, DONE)
//   - legal_part_mask()         : thermometer-from-bit-0 legality check
`ifndef STRUCT_PARTS_LSQ
`define STRUCT_PARTS_LSQ 4
`endif

package lsq_pkg;

  localparam int NUM_PARTS     = `STRUCT_PARTS_LSQ;
  localparam int NUM_PARTS_LOG = (NUM_PARTS > 1) ? $clog2(NUM_PARTS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_WAKE  = 2'd2,
    ST_DONE  = 2'd3
  } lsq_state_e;

  // A mask is legal when bit 0 is set and no cleared bit sits below a set bit
  // (0001, 0011, 0111, ...). Partitions are always powered from the bottom up.
  function automatic logic legal_part_mask(input logic [NUM_PARTS-1:0] mask);
    logic ok;
    ok = mask[0];
    for (int i = 1; i < NUM_PARTS; i++) begin
      if (mask[i] && !mask[i-1]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsq_partition_reconfig_ctrl_if.sv
// Request/response channel between the power/reconfig manager and the
// LSQ partition reconfiguration controller.
//   reconfigReq_i  : manager -> ctrl, request to apply reconfigMask_i
//   reconfigMask_i : manager -> ctrl, requested partition-active mask
//   reconfigAck_o  : ctrl -> manager, 1-cycle pulse, request accepted (drain started)
//   reconfigDone_o : ctrl -> manager, 1-cycle pulse, mask applied and ready
//   reconfigErr_o  : ctrl -> manager, 1-cycle pulse, illegal mask rejected
// Handshake: a request is only sampled while the controller is idle; exactly
// one of ack(+later done), done, or err answers each sampled request.
// Requests seen while busy are dropped and must be re-issued after done.
interface lsq_partition_reconfig_ctrl_if #(
  parameter int NUM_PARTS = 4
);
  logic                 reconfigReq_i;
  logic [NUM_PARTS-1:0] reconfigMask_i;
  logic                 reconfigAck_o;
  logic                 reconfigDone_o;
  logic                 reconfigErr_o;

  modport master (
    output reconfigReq_i, reconfigMask_i,
    input  reconfigAck_o, reconfigDone_o, reconfigErr_o
  );

  modport slave (
    input  reconfigReq_i, reconfigMask_i,
    output reconfigAck_o, reconfigDone_o, reconfigErr_o
  );
endinterface

// File: rtl/lsq_part_wake_timer.sv
// Saturating down-counter that holds newly powered partitions out of use for
// a minimum number of cycles.
//   clk, reset : clock, async active-high reset (counter -> 0)
//   load_i     : load WAKE_CYCLES (takes priority over dec_i)
//   dec_i      : decrement by one, saturating at zero
//   zero_o     : counter is zero
module lsq_part_wake_timer #(
  parameter int WAKE_CYCLES = 4,
  parameter int CNT_W       = $clog2(WAKE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(WAKE_CYCLES);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lsq_partition_reconfig_ctrl.sv
// Owns the LSQ partition-active mask. Accepts a reconfiguration request,
// stalls dispatch while the LDQ/STQ drain, applies the new mask, then waits
// for newly powered partitions to report ready before signalling done.
//   clk, reset           : clock, async active-high reset
//   rcfg (slave)         : request/ack/done/err channel from the reconfig manager
//   ldqEmpty_i           : LDQ holds no valid entries
//   stqEmpty_i           : STQ holds no valid (incl. committed-unretired) entries
//   partReady_i          : per-partition RAM ready
//   lsqPartitionActive_o : registered partition-active mask to the RAMs
//   dispatchStall_o      : block LSQ dispatch (DRAIN or WAKE)
//   lsqReady_o           : idle and every active partition ready
//   dbg_state_o          : current controller state
module lsq_partition_reconfig_ctrl
  import lsq_pkg::*;
#(
  parameter int NUM_PARTS   = lsq_pkg::NUM_PARTS,
  parameter int WAKE_CYCLES = 4,
  parameter int CNT_W       = $clog2(WAKE_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  lsq_partition_reconfig_ctrl_if.slave rcfg,
  input  logic                  ldqEmpty_i,
  input  logic                  stqEmpty_i,
  input  logic [NUM_PARTS-1:0]  partReady_i,
  output logic [NUM_PARTS-1:0]  lsqPartitionActive_o,
  output logic                  dispatchStall_o,
  output logic                  lsqReady_o,
  output lsq_state_e            dbg_state_o
);

  lsq_state_e           state_q, state_d;
  logic [NUM_PARTS-1:0] active_q, active_d;
  logic [NUM_PARTS-1:0] pend_q, pend_d;
  logic [NUM_PARTS-1:0] wake_q, wake_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic                 same_done_q, same_done_d;
  logic                 timer_load;
  logic                 timer_dec;
  logic                 timer_zero;
  logic [NUM_PARTS-1:0] newly_on;

  lsq_part_wake_timer #(
    .WAKE_CYCLES (WAKE_CYCLES),
    .CNT_W       (CNT_W)
  ) u_wake_timer (
    .clk    (clk),
    .reset  (reset),
    .load_i (timer_load),
    .dec_i  (timer_dec),
    .zero_o (timer_zero)
  );

  // Partitions switched on by the pending mask; only these need a wake wait.
  assign newly_on = pend_q & ~active_q;

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    pend_d      = pend_q;
    wake_d      = wake_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    same_done_d = 1'b0;
    timer_load  = 1'b0;
    timer_dec   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rcfg.reconfigReq_i) begin
          if (!legal_part_mask(rcfg.reconfigMask_i)) begin
            err_d = 1'b1;
          end else if (rcfg.reconfigMask_i == active_q) begin
            // Nothing to change: answer done without stalling dispatch.
            same_done_d = 1'b1;
          end else begin
            pend_d  = rcfg.reconfigMask_i;
            ack_d   = 1'b1;   // lands in the first DRAIN cycle
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        // Both queues empty in the same cycle: safe to gate/ungate, since no
        // live entry can sit in a partition that is being switched off.
        if (ldqEmpty_i && stqEmpty_i) begin
          active_d   = pend_q;
          wake_d     = newly_on;
          timer_load = 1'b1;
          state_d    = (newly_on != '0) ? ST_WAKE : ST_DONE;
        end
      end

      ST_WAKE: begin
        timer_dec = 1'b1;
        if (timer_zero && ((partReady_i & wake_q) == wake_q)) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      active_q    <= '1;
      pend_q      <= '0;
      wake_q      <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      same_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      wake_q      <= wake_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      same_done_q <= same_done_d;
    end
  end

  assign lsqPartitionActive_o = active_q;
  assign dispatchStall_o      = (state_q == ST_DRAIN) || (state_q == ST_WAKE);
  assign rcfg.reconfigAck_o   = ack_q;
  assign rcfg.reconfigErr_o   = err_q;
  assign rcfg.reconfigDone_o  = (state_q == ST_DONE) || same_done_q;
  // Inactive partitions never hold up readiness.
  assign lsqReady_o           = (state_q == ST_IDLE) && (&(partReady_i | ~active_q));
  assign dbg_state_o          = state_q;

endmodule

// File: tb/tb_lsq_partition_reconfig_ctrl.sv
module tb_lsq_partition_reconfig_ctrl;
  import lsq_pkg::*;

  localparam int NP = 4;
  localparam int WC = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lsq_partition_reconfig_ctrl_if #(.NUM_PARTS(NP)) rcfg();

  logic          ldq_empty, stq_empty;
  logic [NP-1:0] part_ready;
  logic [NP-1:0] active;
  logic          stall;
  logic          lsq_ready;
  lsq_state_e    dbg_state;

  lsq_partition_reconfig_ctrl #(
    .NUM_PARTS   (NP),
    .WAKE_CYCLES (WC)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .rcfg                 (rcfg.slave),
    .ldqEmpty_i           (ldq_empty),
    .stqEmpty_i           (stq_empty),
    .partReady_i          (part_ready),
    .lsqPartitionActive_o (active),
    .dispatchStall_o      (stall),
    .lsqReady_o           (lsq_ready),
    .dbg_state_o          (dbg_state)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference: mask the model believes is currently applied.
  logic [NP-1:0] cur_active;

  // ---------------- checkers ----------------
  task automatic chk1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%04b expected=%04b", tag, obs, exp);
    end
  endtask

  // Legal = non-zero contiguous run of ones starting at bit 0.
  function automatic bit model_legal(input logic [NP-1:0] m);
    logic [NP-1:0] p1;
    p1 = m + NP'(1);
    return (m != '0) && ((m & p1) == '0);
  endfunction

  // ---------------- driver + expectation for one request ----------------
  // k     : cycles after acceptance during which LDQ/STQ are not both empty
  // r     : cycles after the mask change before new partitions report ready
  // junk  : fire ignored requests while busy
  // stq_only : only stqEmpty is held low during the drain
  task automatic do_req(input logic [NP-1:0] m, input int k, input int r,
                        input bit junk, input bit stq_only);
    bit            legal, same;
    logic [NP-1:0] w;
    int            done_j, gate_j, settle;
    legal = model_legal(m);
    same  = (m == cur_active);

    @(posedge clk); #1;
    rcfg.reconfigReq_i  = 1'b1;
    rcfg.reconfigMask_i = m;
    ldq_empty  = 1'b1;
    stq_empty  = 1'b1;
    part_ready = cur_active;
    @(negedge clk);
    chk1("pre_req_ready", lsq_ready, 1'b1);

    if (!legal || same) begin
      @(posedge clk); #1;
      rcfg.reconfigReq_i  = 1'b0;
      rcfg.reconfigMask_i = NP'($urandom);
      @(negedge clk);
      chk1("nochg_err",    rcfg.reconfigErr_o,  !legal);
      chk1("nochg_done",   rcfg.reconfigDone_o, legal && same);
      chk1("nochg_ack",    rcfg.reconfigAck_o,  1'b0);
      chk1("nochg_stall",  stall,               1'b0);
      chk4("nochg_active", active,              cur_active);
      chk1("nochg_ready",  lsq_ready,           1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      chk1("nochg_err_after",  rcfg.reconfigErr_o,  1'b0);
      chk1("nochg_done_after", rcfg.reconfigDone_o, 1'b0);
      return;
    end

    w      = m & ~cur_active;
    gate_j = k + 2;
    if (w == '0) begin
      done_j = gate_j;
    end else begin
      settle = (WC > r) ? WC : r;
      done_j = gate_j + settle + 1;
    end

    for (int j = 1; j <= done_j + 1; j++) begin
      @(posedge clk); #1;
      rcfg.reconfigReq_i  = (junk && j < done_j) ? 1'($urandom_range(0, 1)) : 1'b0;
      rcfg.reconfigMask_i = NP'($urandom);
      if (j <= k) begin
        if (stq_only) begin
          ldq_empty = 1'b1;
          stq_empty = 1'b0;
        end else begin
          {ldq_empty, stq_empty} = 2'($urandom_range(0, 2));
        end
      end else begin
        ldq_empty = 1'b1;
        stq_empty = 1'b1;
      end
      part_ready = cur_active | ((j >= gate_j + r) ? w : '0);
      @(negedge clk);
      chk1("ack",    rcfg.reconfigAck_o,  j == 1);
      chk1("done",   rcfg.reconfigDone_o, j == done_j);
      chk1("err",    rcfg.reconfigErr_o,  1'b0);
      chk1("stall",  stall,               j < done_j);
      chk4("active", active,              (j >= gate_j) ? m : cur_active);
      chk1("lsq_ready", lsq_ready,        j > done_j);
    end

    cur_active         = m;
    part_ready         = m;
    rcfg.reconfigReq_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset               = 1'b1;
    rcfg.reconfigReq_i  = 1'b0;
    rcfg.reconfigMask_i = '0;
    ldq_empty           = 1'b0;
    stq_empty           = 1'b0;
    part_ready          = '1;

    // 1: reset with traffic on the inputs
    repeat (3) begin
      @(posedge clk); #1;
      rcfg.reconfigReq_i  = 1'($urandom_range(0, 1));
      rcfg.reconfigMask_i = NP'($urandom);
      ldq_empty           = 1'($urandom_range(0, 1));
      stq_empty           = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    chk4("rst_active", active, 4'b1111);
    chk1("rst_stall",  stall, 1'b0);
    chk1("rst_ack",    rcfg.reconfigAck_o, 1'b0);
    chk1("rst_done",   rcfg.reconfigDone_o, 1'b0);
    chk1("rst_err",    rcfg.reconfigErr_o, 1'b0);
    chk1("rst_ready",  lsq_ready, 1'b1);
    chk4("rst_state",  {2'b00, dbg_state}, {2'b00, ST_IDLE});
    #2;
    rcfg.reconfigReq_i = 1'b0;
    ldq_empty          = 1'b1;
    stq_empty          = 1'b1;
    reset              = 1'b0;
    cur_active         = 4'b1111;

    // 2: shrink with empty queues
    do_req(4'b0011, 0, 0, 1'b0, 1'b0);
    // 3: grow, new partitions ready 6 cycles after the mask changes
    do_req(4'b1111, 0, 6, 1'b0, 1'b0);
    // 5: two illegal masks then the current mask
    do_req(4'b0101, 0, 0, 1'b0, 1'b0);
    do_req(4'b0000, 0, 0, 1'b0, 1'b0);
    do_req(4'b1111, 0, 0, 1'b0, 1'b0);
    // 4: shrink while the STQ stays non-empty for 10 cycles
    do_req(4'b0001, 10, 0, 1'b0, 1'b1);

    // 6: reset while waiting for wake
    @(posedge clk); #1;
    rcfg.reconfigReq_i  = 1'b1;
    rcfg.reconfigMask_i = 4'b1111;
    part_ready          = 4'b0001;
    @(posedge clk); #1;
    rcfg.reconfigReq_i  = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk4("wake_state",  {2'b00, dbg_state}, {2'b00, ST_WAKE});
    chk1("wake_stall",  stall, 1'b1);
    chk4("wake_active", active, 4'b1111);
    #2;
    reset = 1'b1;
    #1;
    chk4("rstw_state",  {2'b00, dbg_state}, {2'b00, ST_IDLE});
    chk4("rstw_active", active, 4'b1111);
    chk1("rstw_stall",  stall, 1'b0);
    chk1("rstw_done",   rcfg.reconfigDone_o, 1'b0);
    chk1("rstw_ack",    rcfg.reconfigAck_o, 1'b0);
    @(negedge clk); #2;
    reset      = 1'b0;
    part_ready = 4'b1111;
    cur_active = 4'b1111;
    repeat (3) begin
      @(negedge clk);
      chk1("rstw_no_done", rcfg.reconfigDone_o, 1'b0);
      chk1("rstw_ready",   lsq_ready, 1'b1);
    end

    // random requests
    for (int n = 0; n < 30; n++) begin
      logic [NP-1:0] m;
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 3))
          0:       m = 4'b0001;
          1:       m = 4'b0011;
          2:       m = 4'b0111;
          default: m = 4'b1111;
        endcase
      end else begin
        m = NP'($urandom);
      end
      do_req(m, $urandom_range(0, 4), $urandom_range(0, 6),
             1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
